// File: rtl/decoder_scan_ctrl.sv
// Address/enable sequencer for the one-hot decoder stage: sweeps A over every
// code (up or down), holding each code for dwell+1 cycles, single-shot or continuous.
module decoder_scan_ctrl #(
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               dir,
    input  logic               cont,
    input  logic [DWELL_W-1:0] dwell,
    output logic [ADDR_W-1:0]  A,
    output logic               enable,
    output logic               busy,
    output logic               done,
    output logic               wrap
);

    localparam logic [ADDR_W-1:0] A_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [ADDR_W-1:0]  r_a, w_a_nxt;
    logic               r_enable, w_enable_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_done, w_done_nxt;
    logic               r_wrap, w_wrap_nxt;
    logic [DWELL_W-1:0] r_cnt, w_cnt_nxt;
    logic [DWELL_W-1:0] r_dwell, w_dwell_nxt;
    logic               r_dir, w_dir_nxt;
    logic               r_cont, w_cont_nxt;
    logic [ADDR_W-1:0]  w_first;
    logic [ADDR_W-1:0]  w_last;

    // End points of the sweep for the captured direction
    assign w_first = r_dir ? A_MAX : '0;
    assign w_last  = r_dir ? '0 : A_MAX;

    // State register and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_a      <= '0;
            r_enable <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_wrap   <= 1'b0;
            r_cnt    <= '0;
            r_dwell  <= '0;
            r_dir    <= 1'b0;
            r_cont   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_a      <= w_a_nxt;
            r_enable <= w_enable_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_wrap   <= w_wrap_nxt;
            r_cnt    <= w_cnt_nxt;
            r_dwell  <= w_dwell_nxt;
            r_dir    <= w_dir_nxt;
            r_cont   <= w_cont_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt  = r_state;
        w_a_nxt      = r_a;
        w_enable_nxt = r_enable;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_wrap_nxt   = 1'b0;
        w_cnt_nxt    = r_cnt;
        w_dwell_nxt  = r_dwell;
        w_dir_nxt    = r_dir;
        w_cont_nxt   = r_cont;

        case (r_state)
            ST_IDLE: begin
                // stop wins over a simultaneous start
                if (start && !stop) begin
                    w_dir_nxt    = dir;
                    w_cont_nxt   = cont;
                    w_dwell_nxt  = dwell;
                    w_a_nxt      = dir ? A_MAX : '0;
                    w_enable_nxt = 1'b1;
                    w_busy_nxt   = 1'b1;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (stop) begin
                    w_enable_nxt = 1'b0;
                    w_busy_nxt   = 1'b0;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = ST_IDLE;
                end else if (r_cnt != r_dwell) begin
                    w_cnt_nxt = r_cnt + DWELL_W'(1);
                end else begin
                    w_cnt_nxt = '0;
                    if (r_a != w_last) begin
                        w_a_nxt = r_dir ? (r_a - ADDR_W'(1)) : (r_a + ADDR_W'(1));
                    end else if (r_cont) begin
                        w_a_nxt    = w_first;
                        w_wrap_nxt = 1'b1;
                    end else begin
                        w_enable_nxt = 1'b0;
                        w_busy_nxt   = 1'b0;
                        w_done_nxt   = 1'b1;
                        w_state_nxt  = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_enable_nxt = 1'b0;
                w_busy_nxt   = 1'b0;
            end
        endcase
    end

    assign A      = r_a;
    assign enable = r_enable;
    assign busy   = r_busy;
    assign done   = r_done;
    assign wrap   = r_wrap;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Scoreboard bench for decoder_scan_ctrl: a time-based scan model predicts every
// post-edge output tuple; a monitor pops and compares them one per clock.
module tb_decoder_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start, stop, dir, cont;
    logic [7:0] dwell;
    logic [4:0] A;
    logic       enable, busy, done, wrap;

    decoder_scan_ctrl #(.ADDR_W(5), .DWELL_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .dir(dir),
        .cont(cont), .dwell(dwell), .A(A), .enable(enable), .busy(busy),
        .done(done), .wrap(wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    logic [8:0] q[$];

    // Model state: scan described by elapsed edges since start and captured settings
    bit          m_run, m_post, m_dir, m_cont;
    int unsigned m_t, m_d;
    logic [4:0]  m_a;

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0t: got A=%0d en=%b busy=%b done=%b wrap=%b, expected A=%0d en=%b busy=%b done=%b wrap=%b",
                      name, $time, act[8:4], act[3], act[2], act[1], act[0],
                      exp[8:4], exp[3], exp[2], exp[1], exp[0]);
    endtask

    // Drive inputs for the coming edge, predict its outputs, then advance a cycle
    task automatic cyc(input logic s, input logic p, input logic d, input logic c, input logic [7:0] w);
        logic en, bz, dn, wr;
        int unsigned per, idx;
        en = 1'b0; bz = 1'b0; dn = 1'b0; wr = 1'b0;
        start = s; stop = p; dir = d; cont = c; dwell = w;
        if (!rst_n) begin
            m_run = 0; m_post = 0; m_a = '0;
        end else if (m_run) begin
            if (p) begin
                m_run = 0;
            end else begin
                m_t++;
                per = 32 * (m_d + 1);
                if (!m_cont && m_t == per) begin
                    m_run = 0; m_post = 1; dn = 1'b1;
                end else begin
                    idx = (m_t / (m_d + 1)) % 32;
                    m_a = m_dir ? 5'(31 - idx) : 5'(idx);
                    wr  = m_cont && (m_t % per == 0);
                    en  = 1'b1; bz = 1'b1;
                end
            end
        end else if (m_post) begin
            m_post = 0;
        end else if (s && !p) begin
            m_dir = d; m_cont = c; m_d = w; m_t = 0; m_run = 1;
            m_a = d ? 5'd31 : 5'd0;
            en = 1'b1; bz = 1'b1;
        end
        q.push_back({m_a, en, bz, dn, wr});
        @(negedge clk);
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++)
            cyc(1'b0, 1'b0, 1'($urandom), 1'($urandom), 8'($urandom));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("async_reset", {A, enable, busy, done, wrap}, 9'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        rst_n = 1'b1;
    endtask

    task automatic run_to_a(input logic [4:0] target, input string name);
        int k;
        k = 0;
        while (m_a != target && k < 400) begin
            cyc(1'b0, 1'b0, 1'($urandom), 1'($urandom), 8'($urandom));
            k++;
        end
        if (m_a != target) begin
            n_chk++;
            $display("FAIL %s timeout: model A=%0d never reached %0d", name, m_a, target);
        end
    endtask

    // Monitor: one expected tuple per clock edge, sampled after the edge settles
    initial begin
        logic [8:0] e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("cycle", {A, enable, busy, done, wrap}, e);
            end
        end
    end

    initial begin
        rst_n = 1'b0; start = 0; stop = 0; dir = 0; cont = 0; dwell = '0;
        m_run = 0; m_post = 0; m_dir = 0; m_cont = 0; m_t = 0; m_d = 0; m_a = '0;
        repeat (2) @(negedge clk);
        chk("reset_state", {A, enable, busy, done, wrap}, 9'd0);
        rst_n = 1'b1;
        quiet(3);

        // Fast single up-pass
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        quiet(40);

        // Down-pass, 4 cycles per code
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'd3);
        quiet(140);

        // Continuous, wraps every 64 cycles
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'd1);
        quiet(200);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        quiet(4);

        // Abort mid-dwell at A=10, then restart from 0
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'd5);
        run_to_a(5'd10, "stop_at_10");
        quiet(2);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        quiet(3);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        quiet(36);

        // start with stop in idle is a no-op
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'd7);
        quiet(3);

        // Restart requests with new settings during a scan are ignored, also in DONE
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'd2);
        while (m_run) cyc(1'b1, 1'b0, 1'($urandom), 1'($urandom), 8'($urandom));
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
        quiet(34);

        // Asynchronous reset at A=17, then remain idle
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        run_to_a(5'd17, "reset_at_17");
        do_reset();
        quiet(6);

        // Random traffic
        for (int i = 0; i < 1500; i++)
            cyc(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 49) == 0),
                1'($urandom), 1'($urandom), 8'($urandom_range(0, 3)));
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        quiet(4);

        repeat (2) @(negedge clk);
        if (q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: %0d expected tuples never checked", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
